// File: rtl/crack_ctrl_if.sv
// crack_ctrl_if -- bundle of the crack controller's run-control and result
// signals between a host/channel side (master) and the controller (slave).
//   start        host -> ctrl   run request, level sampled every cycle
//   rdy          chan -> ctrl   per-channel ready (NCH bits)
//   key_in       chan -> ctrl   per-channel key, channel i at [i*KEY_W +: KEY_W]
//   key_valid_in chan -> ctrl   per-channel key-found flag
//   en           ctrl -> chan   one-cycle launch pulse per channel
//   busy/done    ctrl -> host   run status
//   found/key    ctrl -> host   latched result
//   cycles       ctrl -> host   length of the last run in clock cycles
//   hex          ctrl -> host   active-low seven-segment digits of key
interface crack_ctrl_if #(
  parameter int NCH   = 2,
  parameter int KEY_W = 24
);
  logic                     start;
  logic [NCH-1:0]           rdy;
  logic [NCH*KEY_W-1:0]     key_in;
  logic [NCH-1:0]           key_valid_in;
  logic [NCH-1:0]           en;
  logic                     busy;
  logic                     done;
  logic                     found;
  logic [KEY_W-1:0]         key;
  logic [31:0]              cycles;
  logic [(KEY_W/4)*7-1:0]   hex;

  modport master (
    output start, rdy, key_in, key_valid_in,
    input  en, busy, done, found, key, cycles, hex
  );

  modport slave (
    input  start, rdy, key_in, key_valid_in,
    output en, busy, done, found, key, cycles, hex
  );
endinterface

// File: rtl/crack_ctrl.sv
// crack_ctrl -- launches NCH key-cracker channels, waits for them to report,
// latches the lowest-index found key and the run length, and shows the key
// on seven-segment digits.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    crack_ctrl_if.slave (start/rdy/key_in/key_valid_in in,
//          en/busy/done/found/key/cycles/hex out)
// Parameters: NCH (1..4), KEY_W (multiple of 4), TIMEOUT (watchdog limit).
// Optional feature: define CRACK_CTRL_TIMEOUT_EN to enable a watchdog that
// ends a run with found=0 once cycles reaches TIMEOUT.
module crack_ctrl #(
  parameter int          NCH     = 2,
  parameter int          KEY_W   = 24,
  parameter logic [31:0] TIMEOUT = 32'd100_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  crack_ctrl_if.slave  bus
);

  localparam int ND = KEY_W / 4;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_END,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_found;
  logic [KEY_W-1:0] r_key;
  logic [31:0]      r_cycles;

  logic             w_all_rdy;
  logic             w_none_rdy;
  logic [NCH-1:0]   w_hit;
  logic             w_any_hit;
  logic [KEY_W-1:0] w_hit_key;
  logic             w_timeout;
  logic             w_cyc_sat;

  assign w_all_rdy  = &bus.rdy;
  assign w_none_rdy = ~|bus.rdy;
  assign w_hit      = bus.rdy & bus.key_valid_in;
  assign w_any_hit  = |w_hit;
  assign w_cyc_sat  = (r_cycles == '1);

`ifdef CRACK_CTRL_TIMEOUT_EN
  assign w_timeout = (r_cycles >= TIMEOUT);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout = 1'b0;
`endif

  // Lowest-index reporting channel wins: scan from the top so lower indices
  // overwrite higher ones.
  always_comb begin
    w_hit_key = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_hit[NCH-1-i]) w_hit_key = bus.key_in[(NCH-1-i)*KEY_W +: KEY_W];
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    unique case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state logic; the watchdog takes precedence over channel events.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE, DONE: if (bus.start && w_all_rdy) w_state_nx = LAUNCH;
      LAUNCH:     w_state_nx = WAIT_START;
      WAIT_START: begin
        if (w_timeout)       w_state_nx = DONE;
        else if (w_none_rdy) w_state_nx = WAIT_END;
      end
      WAIT_END:   if (w_timeout || w_any_hit || w_all_rdy) w_state_nx = DONE;
      default:    w_state_nx = IDLE;
    endcase
  end

  // Result and run-length registers. found/key are cleared at launch, so a
  // run that ends without a hit (all ready or watchdog) leaves them at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_found  <= 1'b0;
      r_key    <= '0;
      r_cycles <= '0;
    end else begin
      unique case (r_state)
        LAUNCH: begin
          r_found  <= 1'b0;
          r_key    <= '0;
          r_cycles <= '0;
        end
        WAIT_START: begin
          if (!w_timeout && !w_cyc_sat) r_cycles <= r_cycles + 32'd1;
        end
        WAIT_END: begin
          if (!w_timeout) begin
            if (!w_cyc_sat) r_cycles <= r_cycles + 32'd1;
            if (w_any_hit) begin
              r_found <= 1'b1;
              r_key   <= w_hit_key;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.en     = (r_state == LAUNCH) ? '1 : '0;
    bus.busy   = (r_state == LAUNCH) || (r_state == WAIT_START) || (r_state == WAIT_END);
    bus.done   = (r_state == DONE);
    bus.found  = r_found;
    bus.key    = r_key;
    bus.cycles = r_cycles;
    bus.hex    = '1;
    if (r_state == DONE) begin
      for (int unsigned d = 0; d < ND; d++) begin
        bus.hex[d*7 +: 7] = r_found ? glyph(r_key[d*4 +: 4]) : 7'b0111111;
      end
    end
  end

endmodule

// File: tb/tb_crack_ctrl.sv
`timescale 1ns/100ps
module tb_crack_ctrl;
  localparam int NCH   = 2;
  localparam int KEY_W = 24;
  localparam int ND    = KEY_W / 4;
`ifdef CRACK_CTRL_TIMEOUT_EN
  localparam logic [31:0] TO = 32'd20;
`else
  localparam logic [31:0] TO = 32'd100_000_000;
`endif

  localparam logic [6:0] G [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    logic             found;
    logic [KEY_W-1:0] key;
    logic [31:0]      cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  crack_ctrl_if #(.NCH(NCH), .KEY_W(KEY_W)) bus();

  crack_ctrl #(.NCH(NCH), .KEY_W(KEY_W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        q[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  int unsigned      rk[NCH];
  bit               rv[NCH];
  logic [KEY_W-1:0] rkey[NCH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: channel i comes back ready k[i] cycles after the ready drop.
  // The run ends at the earliest return of a valid channel (lowest index on
  // ties), else when the last channel is back; cycles = wait time + 1,
  // unless the watchdog limit is reached first.
  function automatic exp_t predict(input int unsigned k[NCH], input bit v[NCH],
                                   input logic [KEY_W-1:0] kv[NCH]);
    exp_t        e;
    int unsigned t_hit = 32'hFFFF_FFFF;
    int unsigned t_all = 0;
    int unsigned t;
    for (int i = 0; i < NCH; i++) begin
      if (v[i] && k[i] < t_hit) t_hit = k[i];
      if (k[i] > t_all) t_all = k[i];
    end
    e.found = 1'b0;
    e.key   = '0;
    if (t_hit <= t_all) begin
      t = t_hit;
      e.found = 1'b1;
      for (int i = NCH - 1; i >= 0; i--) if (v[i] && k[i] == t_hit) e.key = kv[i];
    end else begin
      t = t_all;
    end
    if (t < TO) e.cycles = t + 1;
    else begin
      e.cycles = TO;
      e.found  = 1'b0;
      e.key    = '0;
    end
    return e;
  endfunction

  function automatic logic [ND*7-1:0] exp_hex(input exp_t e);
    logic [ND*7-1:0] h;
    for (int d = 0; d < ND; d++) h[d*7 +: 7] = e.found ? G[e.key[d*4 +: 4]] : 7'b0111111;
    return h;
  endfunction

  task automatic wait_en(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      seen = (bus.en != '0);
    end
    if (!seen) check("launch_wait", bus.en, {NCH{1'b1}});
  endtask

  task automatic run(input int unsigned k[NCH], input bit v[NCH], input logic [KEY_W-1:0] kv[NCH]);
    int unsigned kmax = 0;
    bit          seen;
    foreach (k[i]) if (k[i] > kmax) kmax = k[i];
    bus.start = 1'b1;
    wait_en(seen);
    if (!seen) return;
    q.push_back(predict(k, v, kv));
    @(posedge clk); #1;
    bus.rdy          = '0;
    bus.key_valid_in = '0;
    for (int unsigned j = 1; j <= kmax; j++) begin
      @(posedge clk); #1;
      if (j == 1000) check("busy_long", bus.busy, (TO > 1000) ? 1 : 0);
      for (int i = 0; i < NCH; i++) begin
        if (k[i] == j) begin
          bus.rdy[i]                     = 1'b1;
          bus.key_valid_in[i]            = v[i];
          bus.key_in[i*KEY_W +: KEY_W]   = kv[i];
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},   bus.busy,   0);
    check({tag, "_done"},   bus.done,   0);
    check({tag, "_found"},  bus.found,  0);
    check({tag, "_key"},    bus.key,    0);
    check({tag, "_cycles"}, bus.cycles, 0);
    check({tag, "_en"},     bus.en,     0);
    check({tag, "_hex"},    bus.hex,    {ND*7{1'b1}});
  endtask

  // Monitor: one en pulse per run, result compared when done rises.
  int unsigned en_cnt    = 0;
  logic        prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.busy && !bus.done) en_cnt = 0;
      if (bus.en == {NCH{1'b1}}) en_cnt++;
      if (bus.done && !prev_done) begin
        if (q.size() == 0) begin
          check("unexpected_done", bus.done, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("found",  bus.found,  e.found);
          check("key",    bus.key,    e.key);
          check("cycles", bus.cycles, e.cycles);
          check("hex",    bus.hex,    exp_hex(e));
          check("en_per_run", en_cnt, 1);
          check("busy_in_done", bus.busy, 0);
        end
        en_cnt = 0;
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    bit seen;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.rdy          = '1;
    bus.key_valid_in = '0;
    bus.key_in       = '0;
    #12.3;
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_start_busy", bus.busy, 0);
    check("idle_no_start_en",   bus.en,   0);

    run('{60, 49}, '{0, 1}, '{24'h000000, 24'h0003FF});
    run('{10, 10}, '{1, 1}, '{24'h000010, 24'h000020});
    run('{5, 12},  '{0, 0}, '{24'h123456, 24'h654321});
    run('{7, 3},   '{1, 0}, '{24'hABCDEF, 24'h111111});
    run('{3, 8},   '{0, 1}, '{24'h222222, 24'h9876A5});
    run('{1, 1},   '{0, 0}, '{24'h000000, 24'h000000});

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NCH; i++) begin
        rk[i]   = $urandom_range(1, 20);
        rv[i]   = 1'($urandom_range(0, 1));
        rkey[i] = KEY_W'($urandom);
      end
      run(rk, rv, rkey);
    end

    // Reset pulse, not clock aligned, while waiting for the channels.
    bus.start = 1'b1;
    wait_en(seen);
    @(posedge clk); #1;
    bus.rdy          = '0;
    bus.key_valid_in = '0;
    repeat (4) @(posedge clk);
    #3.3 rst_n = 1'b0;
    #0.5 check_reset_vals("midrun_reset");
    #0.5 rst_n = 1'b1;
    bus.start = 1'b0;
    bus.rdy   = '1;
    repeat (3) @(negedge clk);
    check("post_reset_busy", bus.busy, 0);
    check("post_reset_en",   bus.en,   0);
    check("post_reset_done", bus.done, 0);

    run('{4, 6}, '{0, 1}, '{24'h0C0FFE, 24'hBEEF01});
    run('{1005, 1005}, '{0, 0}, '{24'h000000, 24'h000000});
    bus.start = 1'b0;

    for (int c = 0; c < 2000 && q.size() != 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
